async_fifo_read_arbiter: RTL and testbench

ASYNC_FIFO_READ_ARBITER -- requirements
Module: async_fifo_read_arbiter

---
 rtl/async_fifo_read_arbiter.sv | 107 ++++++++++
 tb/tb_async_fifo_read_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_read_arbiter.sv
// Read-side arbiter sharing one FIFO read port among NUM_REQ consumers.
// Round-robin grant, bursts of up to MAX_BURST pops, one IDLE bubble between grants.
module async_fifo_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    cons_ready,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_pop,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    cons_valid,
    output logic [DATA_WIDTH-1:0] cons_data,
    output logic                  busy
);

    localparam int unsigned NR    = NUM_REQ;
    localparam int          IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_last_grant;
    logic [CNT_W-1:0]   r_beat;

    logic               w_found;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W-1:0]   w_cand;
    int unsigned        w_probe;
    logic               w_req_g;
    logic [NUM_REQ-1:0] w_valid;
    logic               w_pop;

    // Round-robin search upward from last_grant+1, wrapping at NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last_grant;
        w_cand  = '0;
        w_probe = 0;
        for (int unsigned k = 1; k <= NR; k++) begin
            w_probe = 32'(r_last_grant) + k;
            if (w_probe >= NR) w_probe = w_probe - NR;
            w_cand = IDX_W'(w_probe);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // r_grant is zero outside BURST, so valid/pop need no separate state qualifier.
    assign w_req_g = |(r_grant & req);
    assign w_valid = r_grant & req & {NUM_REQ{~fifo_empty}};
    assign w_pop   = |(w_valid & cons_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= LAST_RST;
            r_beat       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state      <= BURST;
                        r_grant      <= NUM_REQ'(1) << w_sel;
                        r_last_grant <= w_sel;
                        r_beat       <= '0;
                    end
                end
                BURST: begin
                    if (!w_req_g || (w_pop && (r_beat == LAST_BEAT))) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_beat  <= '0;
                    end else if (w_pop) begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_beat  <= '0;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign cons_valid = w_valid;
    assign fifo_pop   = w_pop;
    assign cons_data  = fifo_rd_data;
    assign busy       = (r_state == BURST);

endmodule

// File: tb/tb_async_fifo_read_arbiter.sv
// Self-checking bench for async_fifo_read_arbiter: FIFO model plus data scoreboard,
// a table of arbitration vectors and hand-written burst/reset sequences.
module tb_async_fifo_read_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk;
    logic          reset_n;
    logic [NR-1:0] req;
    logic [NR-1:0] cons_ready;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_pop;
    logic [NR-1:0] grant;
    logic [NR-1:0] cons_valid;
    logic [DW-1:0] cons_data;
    logic          busy;

    async_fifo_read_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .cons_ready  (cons_ready),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_pop    (fifo_pop),
        .grant       (grant),
        .cons_valid  (cons_valid),
        .cons_data   (cons_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] grant;
    } arb_vec_t;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            n_pass  = 0;
    int            n_total = 0;
    logic          obs_pop = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive_fifo();
        fifo_empty   = (fifo_q.size() == 0);
        fifo_rd_data = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
        drive_fifo();
    endtask

    // Observe the current cycle away from the active edge.
    task automatic obs();
        logic [DW-1:0] e;
        @(negedge clk);
        obs_pop = fifo_pop;
        chk("pop_while_empty", 32'(fifo_pop & fifo_empty), 32'd0);
        chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        chk("cons_data_pass", 32'(cons_data), 32'(fifo_rd_data));
        if (fifo_pop) begin
            if (exp_q.size() == 0) chk("pop_underflow", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("pop_data", 32'(cons_data), 32'(e));
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        if (obs_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        obs_pop = 1'b0;
        drive_fifo();
    endtask

    task automatic cyc(input string tag, input logic [NR-1:0] eg, input logic ep, input logic eb);
        logic [NR-1:0] ev;
        obs();
        ev = fifo_empty ? '0 : (eg & req);
        chk({tag, "_grant"}, 32'(grant), 32'(eg));
        chk({tag, "_pop"}, 32'(fifo_pop), 32'(ep));
        chk({tag, "_busy"}, 32'(busy), 32'(eb));
        chk({tag, "_valid"}, 32'(cons_valid), 32'(ev));
        adv();
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req        = '0;
        cons_ready = '0;
        fifo_q.delete();
        exp_q.delete();
        drive_fifo();
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_pop", 32'(fifo_pop), 32'd0);
        chk("rst_valid", 32'(cons_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        obs_pop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arb_vec_t tbl[8];
        tbl[0] = '{req: 4'b0100, grant: 4'b0100};
        tbl[1] = '{req: 4'b1011, grant: 4'b1000};
        tbl[2] = '{req: 4'b1011, grant: 4'b0001};
        tbl[3] = '{req: 4'b1011, grant: 4'b0010};
        tbl[4] = '{req: 4'b0101, grant: 4'b0100};
        tbl[5] = '{req: 4'b0011, grant: 4'b0001};
        tbl[6] = '{req: 4'b0001, grant: 4'b0001};
        tbl[7] = '{req: 4'b1110, grant: 4'b0010};

        // Arbitration table: FIFO empty, each grant ended by dropping req.
        do_reset();
        cons_ready = '1;
        for (int i = 0; i < 8; i++) begin
            req = tbl[i].req;
            cyc("tbl_idle", '0, 1'b0, 1'b0);
            cyc("tbl_grant", tbl[i].grant, 1'b0, 1'b1);
            req = '0;
            cyc("tbl_drop", tbl[i].grant, 1'b0, 1'b1);
        end

        // Single requester, 6 entries: 4-pop burst, bubble, regrant, 2 pops.
        do_reset();
        for (int i = 0; i < 6; i++) push(8'(8'hA0 + i));
        cons_ready = '1;
        req = 4'b0010;
        cyc("a_idle0", '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("a_burst1", 4'b0010, 1'b1, 1'b1);
        cyc("a_idle1", '0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc("a_burst2", 4'b0010, 1'b1, 1'b1);
        cyc("a_empty", 4'b0010, 1'b0, 1'b1);

        // All requesting, FIFO never empty: rotation 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 30; i++) push(8'(8'h30 + i));
        cons_ready = '1;
        req = '1;
        for (int k = 0; k < 5; k++) begin
            cyc("b_idle", '0, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) cyc("b_burst", 4'(1 << (k % 4)), 1'b1, 1'b1);
        end

        // Consumer 2 with ready toggling: pops only in ready cycles.
        do_reset();
        for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
        req = 4'b0100;
        cyc("c_idle", '0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            cons_ready = (i % 2 == 0) ? 4'b0100 : 4'b0000;
            cyc("c_burst", 4'b0100, (i % 2 == 0), 1'b1);
        end
        cyc("c_exit", '0, 1'b0, 1'b0);

        // Grant held through 10 empty cycles, then a single pop.
        do_reset();
        cons_ready = '1;
        req = 4'b0001;
        cyc("d_idle", '0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc("d_wait", 4'b0001, 1'b0, 1'b1);
        push(8'hD0);
        cyc("d_pop", 4'b0001, 1'b1, 1'b1);
        cyc("d_hold", 4'b0001, 1'b0, 1'b1);

        // req[3] dropped after 2 pops: exit with no pop, next grant to 0.
        do_reset();
        for (int i = 0; i < 6; i++) push(8'(8'hE0 + i));
        cons_ready = '1;
        req = 4'b1000;
        cyc("e_idle0", '0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc("e_burst", 4'b1000, 1'b1, 1'b1);
        req = 4'b0001;
        cyc("e_drop", 4'b1000, 1'b0, 1'b1);
        cyc("e_idle1", '0, 1'b0, 1'b0);
        cyc("e_regrant", 4'b0001, 1'b1, 1'b1);

        // Asynchronous reset mid-burst after 1 pop, then fresh priority from 0.
        do_reset();
        for (int i = 0; i < 6; i++) push(8'(8'hF0 + i));
        cons_ready = '1;
        req = 4'b0100;
        cyc("f_idle0", '0, 1'b0, 1'b0);
        cyc("f_burst", 4'b0100, 1'b1, 1'b1);
        #1;
        chk("f_pre_rst_pop", 32'(fifo_pop), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("f_rst_pop", 32'(fifo_pop), 32'd0);
        chk("f_rst_valid", 32'(cons_valid), 32'd0);
        chk("f_rst_busy", 32'(busy), 32'd0);
        chk("f_rst_grant", 32'(grant), 32'd0);
        #1;
        reset_n = 1'b1;
        req = '1;
        cyc("f_idle1", '0, 1'b0, 1'b0);
        cyc("f_first", 4'b0001, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
